// File: rtl/issue_queue_pkg.sv
// Shared types and widths for the issue queue: tag/sequence widths, the
// per-entry storage record, and the wakeup tag-match helper.
package issue_queue_pkg;

   localparam int PHYS_TAG_W = 6;
   localparam int SEQ_W      = 32;
   localparam int IQ_INFO_W  = 170;

   typedef struct packed {
      logic                  valid;
      logic                  rdy1;
      logic                  rdy2;
      logic [PHYS_TAG_W-1:0] src1_map;
      logic [PHYS_TAG_W-1:0] src2_map;
      logic [PHYS_TAG_W-1:0] regwr_map;
      logic                  regwr_flag;
      logic [SEQ_W-1:0]      instr_num;
      logic [IQ_INFO_W-1:0]  all_info;
   } iq_entry_t;

   function automatic logic tag_hit(input logic                  flag,
                                    input logic [PHYS_TAG_W-1:0] bcast_map,
                                    input logic [PHYS_TAG_W-1:0] src_map);
      return flag && (bcast_map == src_map);
   endfunction

endpackage

// File: rtl/issue_queue_age_select.sv
// Oldest-first picker: one-hot grant to the eligible entry with the lowest
// sequence number; equal sequence numbers resolve to the lowest index.
module iq_age_select
   import issue_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]       elig_i,
   input  logic [DEPTH*SEQ_W-1:0] seq_i,
   output logic [DEPTH-1:0]       grant_o,
   output logic                   grant_valid_o
);

   logic [SEQ_W-1:0] best_seq;
   logic             found;

   always_comb begin
      grant_o  = '0;
      found    = 1'b0;
      best_seq = '0;
      for (int i = 0; i < DEPTH; i++) begin
         // strict compare keeps the lower index on a tie
         if (elig_i[i] && (!found || (seq_i[i*SEQ_W +: SEQ_W] < best_seq))) begin
            grant_o    = '0;
            grant_o[i] = 1'b1;
            found      = 1'b1;
            best_seq   = seq_i[i*SEQ_W +: SEQ_W];
         end
      end
      grant_valid_o = found;
   end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue with tag wakeup and oldest-first select.
// Define IQ_FAST_WAKEUP_EN to let a broadcast make an entry selectable in the same cycle.
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int INFO_W = IQ_INFO_W
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  dispatch_valid,
   output logic                  dispatch_ready,
   input  logic [31:0]           dispatch_instr_num,
   input  logic                  dispatch_src1_used,
   input  logic                  dispatch_src2_used,
   input  logic [5:0]            dispatch_src1_map,
   input  logic [5:0]            dispatch_src2_map,
   input  logic                  dispatch_src1_rdy,
   input  logic                  dispatch_src2_rdy,
   input  logic [5:0]            dispatch_RegWr_map,
   input  logic                  dispatch_RegWr_flag,
   input  logic [INFO_W-1:0]     dispatch_all_info,
   input  logic                  broadcast_flag,
   input  logic [5:0]            broadcast_map,
   input  logic                  flush,
   input  logic                  issue_ready,
   output logic                  issue_valid,
   output logic [31:0]           issue_instr_num,
   output logic [5:0]            issue_src1_map,
   output logic [5:0]            issue_src2_map,
   output logic [5:0]            issue_RegWr_map,
   output logic                  issue_RegWr_flag,
   output logic [INFO_W-1:0]     issue_all_info,
   output logic [$clog2(DEPTH):0] iq_count,
   output logic                  iq_full,
   output logic                  iq_empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   iq_entry_t             entries_q [DEPTH];
   iq_entry_t             disp_entry;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  issue_valid_q, issue_regwr_flag_q;
   logic [SEQ_W-1:0]      issue_instr_num_q;
   logic [PHYS_TAG_W-1:0] issue_src1_map_q, issue_src2_map_q, issue_regwr_map_q;
   logic [INFO_W-1:0]     issue_all_info_q;

   logic [DEPTH-1:0]       rdy1_w, rdy2_w, elig, grant;
   logic [DEPTH*SEQ_W-1:0] seq_flat;
   logic                   grant_valid, dispatch_fire, issue_fire;
   logic [IDX_W-1:0]       free_idx;
   logic                   free_found;

   assign iq_full        = (count_q == CNT_W'(DEPTH));
   assign iq_empty       = (count_q == '0);
   assign dispatch_ready = !iq_full && !flush;
   assign dispatch_fire  = dispatch_valid && dispatch_ready;

   always_comb begin
      rdy1_w   = '0;
      rdy2_w   = '0;
      elig     = '0;
      seq_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rdy1_w[i] = entries_q[i].rdy1 | tag_hit(broadcast_flag, broadcast_map, entries_q[i].src1_map);
         rdy2_w[i] = entries_q[i].rdy2 | tag_hit(broadcast_flag, broadcast_map, entries_q[i].src2_map);
`ifdef IQ_FAST_WAKEUP_EN
         elig[i] = entries_q[i].valid && rdy1_w[i] && rdy2_w[i];
`else
         elig[i] = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
`endif
         seq_flat[i*SEQ_W +: SEQ_W] = entries_q[i].instr_num;
      end
   end

   iq_age_select #(.DEPTH(DEPTH)) u_age_select (
      .elig_i        (elig),
      .seq_i         (seq_flat),
      .grant_o       (grant),
      .grant_valid_o (grant_valid)
   );

   assign issue_fire = issue_ready && grant_valid;

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!entries_q[i].valid && !free_found) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // Payload storage is sized by IQ_INFO_W; a different INFO_W pads or truncates.
   always_comb begin
      disp_entry            = '0;
      disp_entry.valid      = 1'b1;
      disp_entry.rdy1       = !dispatch_src1_used || dispatch_src1_rdy ||
                              tag_hit(broadcast_flag, broadcast_map, dispatch_src1_map);
      disp_entry.rdy2       = !dispatch_src2_used || dispatch_src2_rdy ||
                              tag_hit(broadcast_flag, broadcast_map, dispatch_src2_map);
      disp_entry.src1_map   = dispatch_src1_map;
      disp_entry.src2_map   = dispatch_src2_map;
      disp_entry.regwr_map  = dispatch_RegWr_map;
      disp_entry.regwr_flag = dispatch_RegWr_flag;
      disp_entry.instr_num  = dispatch_instr_num;
      disp_entry.all_info   = IQ_INFO_W'(dispatch_all_info);
      count_d               = count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         count_q            <= '0;
         issue_valid_q      <= 1'b0;
         issue_instr_num_q  <= '0;
         issue_src1_map_q   <= '0;
         issue_src2_map_q   <= '0;
         issue_regwr_map_q  <= '0;
         issue_regwr_flag_q <= 1'b0;
         issue_all_info_q   <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
         count_q       <= '0;
         issue_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid) begin
               entries_q[i].rdy1 <= rdy1_w[i];
               entries_q[i].rdy2 <= rdy2_w[i];
            end
            if (issue_ready && grant[i]) begin
               entries_q[i].valid <= 1'b0;
               issue_instr_num_q  <= entries_q[i].instr_num;
               issue_src1_map_q   <= entries_q[i].src1_map;
               issue_src2_map_q   <= entries_q[i].src2_map;
               issue_regwr_map_q  <= entries_q[i].regwr_map;
               issue_regwr_flag_q <= entries_q[i].regwr_flag;
               issue_all_info_q   <= INFO_W'(entries_q[i].all_info);
            end
         end
         if (issue_ready) issue_valid_q <= grant_valid;
         // free slot is never the granted one: granted entries are valid
         if (dispatch_fire) entries_q[free_idx] <= disp_entry;
         count_q <= count_d;
      end
   end

   assign issue_valid      = issue_valid_q;
   assign issue_instr_num  = issue_instr_num_q;
   assign issue_src1_map   = issue_src1_map_q;
   assign issue_src2_map   = issue_src2_map_q;
   assign issue_RegWr_map  = issue_regwr_map_q;
   assign issue_RegWr_flag = issue_regwr_flag_q;
   assign issue_all_info   = issue_all_info_q;
   assign iq_count         = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, latency, wakeup, age order, full,
// flush, dispatch bypass, net-zero count and mid-run reset.
module tb_issue_queue;

   localparam int DEPTH  = 8;
   localparam int INFO_W = 170;
`ifdef IQ_FAST_WAKEUP_EN
   localparam logic FAST = 1'b1;
`else
   localparam logic FAST = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RESET;
   logic              dispatch_valid, dispatch_ready;
   logic [31:0]       dispatch_instr_num;
   logic              dispatch_src1_used, dispatch_src2_used;
   logic [5:0]        dispatch_src1_map, dispatch_src2_map;
   logic              dispatch_src1_rdy, dispatch_src2_rdy;
   logic [5:0]        dispatch_RegWr_map;
   logic              dispatch_RegWr_flag;
   logic [INFO_W-1:0] dispatch_all_info;
   logic              broadcast_flag;
   logic [5:0]        broadcast_map;
   logic              flush, issue_ready, issue_valid;
   logic [31:0]       issue_instr_num;
   logic [5:0]        issue_src1_map, issue_src2_map, issue_RegWr_map;
   logic              issue_RegWr_flag;
   logic [INFO_W-1:0] issue_all_info;
   logic [3:0]        iq_count;
   logic              iq_full, iq_empty;

   int n_cmp, n_err;

   always #5 CLK = ~CLK;

   issue_queue #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_instr_num(dispatch_instr_num),
      .dispatch_src1_used(dispatch_src1_used), .dispatch_src2_used(dispatch_src2_used),
      .dispatch_src1_map(dispatch_src1_map), .dispatch_src2_map(dispatch_src2_map),
      .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
      .dispatch_RegWr_map(dispatch_RegWr_map), .dispatch_RegWr_flag(dispatch_RegWr_flag),
      .dispatch_all_info(dispatch_all_info),
      .broadcast_flag(broadcast_flag), .broadcast_map(broadcast_map),
      .flush(flush), .issue_ready(issue_ready), .issue_valid(issue_valid),
      .issue_instr_num(issue_instr_num),
      .issue_src1_map(issue_src1_map), .issue_src2_map(issue_src2_map),
      .issue_RegWr_map(issue_RegWr_map), .issue_RegWr_flag(issue_RegWr_flag),
      .issue_all_info(issue_all_info),
      .iq_count(iq_count), .iq_full(iq_full), .iq_empty(iq_empty)
   );

   function automatic logic [INFO_W-1:0] make_info(input logic [31:0] num);
      logic [INFO_W-1:0] v;
      v = '0;
      v[31:0] = num;
      v[INFO_W-1 -: 32] = ~num;
      return v;
   endfunction

   task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      dispatch_valid = 1'b0;
      broadcast_flag = 1'b0;
      broadcast_map  = '0;
      flush          = 1'b0;
   endtask

   task automatic disp(input logic [31:0] num,
                       input logic u1, input logic r1, input logic [5:0] m1,
                       input logic u2, input logic r2, input logic [5:0] m2);
      dispatch_valid      = 1'b1;
      dispatch_instr_num  = num;
      dispatch_src1_used  = u1;
      dispatch_src1_rdy   = r1;
      dispatch_src1_map   = m1;
      dispatch_src2_used  = u2;
      dispatch_src2_rdy   = r2;
      dispatch_src2_map   = m2;
      dispatch_RegWr_map  = num[5:0];
      dispatch_RegWr_flag = 1'b1;
      dispatch_all_info   = make_info(num);
   endtask

   task automatic bcast(input logic [5:0] m);
      broadcast_flag = 1'b1;
      broadcast_map  = m;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      RESET = 1'b1;
      issue_ready = 1'b0;
      idle_in();
      disp(0, 0, 0, 0, 0, 0, 0);
      dispatch_valid = 1'b0;
      tick();
      tick();
      RESET = 1'b0;
      check_val("rst_count", iq_count, 0);
      check_val("rst_empty", iq_empty, 1);
      check_val("rst_full", iq_full, 0);
      check_val("rst_ivalid", issue_valid, 0);
      check_val("rst_inum", issue_instr_num, 0);
      check_val("rst_info", issue_all_info, 0);
      check_val("rst_dready", dispatch_ready, 1);

      // single ready op: one-cycle latency
      issue_ready = 1'b1;
      disp(5, 1, 1, 3, 1, 1, 4);
      tick();
      idle_in();
      check_val("t1_count_in", iq_count, 1);
      check_val("t1_ivalid_early", issue_valid, 0);
      tick();
      check_val("t1_ivalid", issue_valid, 1);
      check_val("t1_inum", issue_instr_num, 5);
      check_val("t1_src1", issue_src1_map, 3);
      check_val("t1_src2", issue_src2_map, 4);
      check_val("t1_wmap", issue_RegWr_map, 5);
      check_val("t1_wflag", issue_RegWr_flag, 1);
      check_val("t1_info", issue_all_info, make_info(5));
      check_val("t1_count", iq_count, 0);
      tick();
      check_val("t1_ivalid_drop", issue_valid, 0);

      // wakeup by broadcast two cycles after dispatch
      disp(7, 1, 0, 12, 0, 0, 0);
      tick();
      idle_in();
      tick();
      check_val("t2_wait", issue_valid, 0);
      bcast(12);
      tick();
      idle_in();
      check_val("t2_bcast_cyc", issue_valid, FAST);
      tick();
      check_val("t2_next_cyc", issue_valid, !FAST);
      check_val("t2_inum", issue_instr_num, 7);
      check_val("t2_count", iq_count, 0);
      tick();
      check_val("t2_clear", issue_valid, 0);

      // age ordering with issue held off, then a hold cycle
      issue_ready = 1'b0;
      disp(9, 1, 1, 1, 1, 1, 2);
      tick();
      disp(3, 1, 1, 1, 1, 1, 2);
      tick();
      idle_in();
      check_val("t3_count", iq_count, 2);
      check_val("t3_held_off", issue_valid, 0);
      issue_ready = 1'b1;
      tick();
      check_val("t3_first_v", issue_valid, 1);
      check_val("t3_first", issue_instr_num, 3);
      issue_ready = 1'b0;
      tick();
      check_val("t3_hold_v", issue_valid, 1);
      check_val("t3_hold_num", issue_instr_num, 3);
      check_val("t3_hold_cnt", iq_count, 1);
      issue_ready = 1'b1;
      tick();
      check_val("t3_second", issue_instr_num, 9);
      check_val("t3_count0", iq_count, 0);
      tick();
      check_val("t3_drain", issue_valid, 0);

      // fill to full, overflow attempt, wake one, then a shared tag wakes two
      for (int i = 0; i < DEPTH; i++) begin
         disp(100 + i, 1, 0, (i >= 6) ? 6'd50 : 6'(32 + i), 0, 0, 0);
         tick();
      end
      idle_in();
      check_val("t4_count8", iq_count, 8);
      check_val("t4_full", iq_full, 1);
      check_val("t4_dready", dispatch_ready, 0);
      disp(200, 1, 1, 1, 1, 1, 2);
      tick();
      idle_in();
      check_val("t4_overflow_cnt", iq_count, 8);
      check_val("t4_overflow_iv", issue_valid, 0);
      bcast(35);
      tick();
      idle_in();
      tick();
      check_val("t4_w1_num", issue_instr_num, 103);
      check_val("t4_w1_v", issue_valid, !FAST);
      check_val("t4_w1_cnt", iq_count, 7);
      check_val("t4_notfull", iq_full, 0);
      check_val("t4_dready1", dispatch_ready, 1);
      bcast(50);
      tick();
      idle_in();
      tick();
      check_val("t4_multi_a", issue_instr_num, FAST ? 32'd107 : 32'd106);
      tick();
      check_val("t4_multi_b", issue_instr_num, 107);
      check_val("t4_multi_cnt", iq_count, 5);
      flush = 1'b1;
      tick();
      idle_in();
      check_val("t4_flush_cnt", iq_count, 0);
      check_val("t4_flush_empty", iq_empty, 1);

      // flush beats dispatch, broadcast and issue
      issue_ready = 1'b0;
      disp(60, 1, 0, 45, 0, 0, 0);
      tick();
      disp(61, 1, 0, 45, 0, 0, 0);
      tick();
      disp(62, 1, 0, 45, 0, 0, 0);
      tick();
      disp(64, 1, 1, 1, 1, 1, 2);
      tick();
      idle_in();
      check_val("t5_count4", iq_count, 4);
      disp(70, 1, 1, 1, 1, 1, 2);
      bcast(45);
      flush = 1'b1;
      issue_ready = 1'b1;
      tick();
      idle_in();
      check_val("t5_cnt", iq_count, 0);
      check_val("t5_iv", issue_valid, 0);
      check_val("t5_empty", iq_empty, 1);
      tick();
      tick();
      check_val("t5_absent_iv", issue_valid, 0);
      check_val("t5_absent_cnt", iq_count, 0);

      // dispatch-cycle wakeup bypass
      disp(11, 1, 0, 20, 0, 0, 0);
      bcast(20);
      tick();
      idle_in();
      check_val("t6_cnt", iq_count, 1);
      tick();
      check_val("t6_iv", issue_valid, 1);
      check_val("t6_num", issue_instr_num, 11);
      check_val("t6_cnt0", iq_count, 0);

      // simultaneous dispatch and issue
      disp(80, 1, 1, 1, 1, 1, 2);
      tick();
      disp(81, 1, 0, 55, 0, 0, 0);
      tick();
      idle_in();
      check_val("t7_net_cnt", iq_count, 1);
      check_val("t7_iv", issue_valid, 1);
      check_val("t7_num", issue_instr_num, 80);

      // reset mid-operation dominates dispatch and broadcast
      RESET = 1'b1;
      disp(90, 1, 1, 1, 1, 1, 2);
      bcast(55);
      tick();
      RESET = 1'b0;
      idle_in();
      check_val("t8_cnt", iq_count, 0);
      check_val("t8_iv", issue_valid, 0);
      check_val("t8_num", issue_instr_num, 0);
      check_val("t8_empty", iq_empty, 1);
      tick();
      check_val("t8_after_iv", issue_valid, 0);
      check_val("t8_after_cnt", iq_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries (power of two, 4..16).
REQ-002 Parameter INFO_W, default 170, width of the per-instruction all_info payload.
REQ-003 CLK  in  1  single clock, all state updates on posedge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 dispatch_valid  in  1  dispatch offers one instruction this cycle.
REQ-006 dispatch_ready  out  1  queue accepts the offered instruction.
REQ-007 dispatch_instr_num  in  32  program-order sequence number; lower is older.
REQ-008 dispatch_src1_used/dispatch_src2_used  in  1 each  operand needs a physical register.
REQ-009 dispatch_src1_map/dispatch_src2_map  in  6 each  physical source tags.
REQ-010 dispatch_src1_rdy/dispatch_src2_rdy  in  1 each  operand already available at dispatch.
REQ-011 dispatch_RegWr_map  in  6, dispatch_RegWr_flag  in  1  destination tag and write flag.
REQ-012 dispatch_all_info  in  INFO_W  opaque payload.
REQ-013 broadcast_flag  in  1, broadcast_map  in  6  EXE completion tag.
REQ-014 flush  in  1  EXE mispredict, clear queue.
REQ-015 issue_ready  in  1  EXE can accept an instruction.
REQ-016 issue_valid  out  1, issue_instr_num  out  32, issue_src1_map/issue_src2_map  out  6 each, issue_RegWr_map  out  6, issue_RegWr_flag  out  1, issue_all_info  out  INFO_W  registered issue bundle.
REQ-017 iq_count  out  log2(DEPTH)+1  occupied entries; iq_full/iq_empty  out  1 each.

Function
REQ-018 dispatch_ready SHALL equal !iq_full && !flush, from registered count; no credit for a same-cycle issue.
REQ-019 Accepted dispatch SHALL write the lowest-index free entry at posedge.
REQ-020 Operand ready bit SHALL be set if !used, or rdy at dispatch, or broadcast_flag with broadcast_map == operand map in the dispatch cycle (dispatch-cycle wakeup bypass).
REQ-021 Every cycle with broadcast_flag, each valid entry SHALL set any operand ready bit whose map equals broadcast_map; multiple matches all wake.
REQ-022 Entry is eligible when valid and both operand ready bits set (timing per REQ-031).
REQ-023 When issue_ready=1: select eligible entry with lowest instr_num (ties: lowest index), load issue bundle, free entry, issue_valid<=1; if none eligible, issue_valid<=0.
REQ-024 When issue_ready=0: issue bundle and issue_valid SHALL hold; no entry freed.
REQ-025 Issue latency: dispatch with ready operands at posedge N -> issue_valid at posedge N+1 earliest.
REQ-026 Simultaneous dispatch and issue SHALL update count by net zero; count never exceeds DEPTH or underflows.
REQ-027 flush SHALL invalidate all entries, force issue_valid<=0, drop same-cycle dispatch; flush overrides broadcast and issue.
REQ-028 instr_num wrap-around not supported; comparison is unsigned 32-bit.

Reset
REQ-029 RESET=1 at posedge SHALL clear all valid bits, iq_count=0, iq_empty=1, iq_full=0, issue_valid=0, all issue bundle fields 0; mid-operation reset discards all entries.
REQ-030 RESET SHALL dominate flush, dispatch, broadcast.

Configuration
REQ-031 Macro IQ_FAST_WAKEUP_EN defined: broadcast in cycle N makes entry eligible for selection in cycle N (combinational wakeup-to-select); undefined: eligible in cycle N+1 only.

Structure
REQ-032 Shared package holds PHYS_TAG_W=6, SEQ_W=32, entry struct typedef (valid, rdy1, rdy2, maps, flags, instr_num, all_info).
REQ-033 One sub-module iq_age_select: DEPTH eligible bits plus instr_nums -> one-hot oldest grant and valid.

Verification
REQ-034 Dispatch instr_num=5, both rdy=1, issue_ready=1 -> issue_valid=1 next cycle, issue_instr_num=5, iq_count back to 0.
REQ-035 Dispatch #7 src1_map=12 not ready; broadcast_map=12 two cycles later -> issues same cycle as broadcast+1 with IQ_FAST_WAKEUP_EN, +2 without.
REQ-036 Dispatch #9 then #3, both ready, issue_ready held 0 then 1 -> #3 issues first, #9 next cycle.
REQ-037 Fill 8 entries with unready ops -> iq_full=1, dispatch_ready=0; 9th dispatch ignored; broadcast frees one per issue.
REQ-038 4 entries, flush=1 with dispatch_valid=1 and broadcast -> iq_count=0, issue_valid=0 next cycle, dispatched op absent.
REQ-039 Dispatch src1_map=20 with broadcast_flag, broadcast_map=20 same cycle -> entry ready, issues next cycle.
